// File: rtl/ctc_pkg.sv
// Shared types for the control-and-timing word sequencer: WS field codes,
// instruction-type patterns and pointer operations.
package ctc_pkg;

    typedef enum logic [2:0] {
        WS_P  = 3'b000,
        WS_WP = 3'b001,
        WS_X  = 3'b010,
        WS_XS = 3'b011,
        WS_M  = 3'b100,
        WS_MS = 3'b101,
        WS_W  = 3'b110,
        WS_S  = 3'b111
    } ws_field_e;

    typedef enum logic [1:0] {
        P_SET  = 2'b00,
        P_TEST = 2'b01,
        P_DEC  = 2'b10,
        P_INC  = 2'b11
    } ptr_op_e;

    localparam logic [1:0] ITYPE_ARITH = 2'b10;
    localparam logic [3:0] IPTR        = 4'b1100;

endpackage

// File: rtl/ctc_ws_decode.sv
// Word-select field decode: asserts ws while the current digit lies inside
// the selected field of the word.
module ctc_ws_decode
    import ctc_pkg::*;
#(
    parameter int DIGITS     = 14,
    parameter int EXP_DIGITS = 2,
    localparam int PW        = $clog2(DIGITS)
) (
    input  ws_field_e       field,
    input  logic [PW-1:0]   digit,
    input  logic [PW-1:0]   p,
    input  logic            ws_en,
    output logic            ws
);

    localparam logic [PW-1:0] EXP_D  = PW'(EXP_DIGITS);
    localparam logic [PW-1:0] LAST_D = PW'(DIGITS - 1);

    logic in_field;

    always_comb begin
        in_field = 1'b0;
        case (field)
            WS_P:    in_field = (digit == p);
            WS_WP:   in_field = (digit <= p);
            WS_X:    in_field = (digit < EXP_D);
            WS_XS:   in_field = (digit == EXP_D);
            WS_M:    in_field = (digit > EXP_D) && (digit < LAST_D);
            WS_MS:   in_field = (digit > EXP_D);
            WS_W:    in_field = 1'b1;
            WS_S:    in_field = (digit == LAST_D);
            default: in_field = 1'b0;
        endcase
    end

    assign ws = ws_en & in_field;

endmodule

// File: rtl/ctc_word_timer.sv
// Bit-serial word timing, instruction capture, pointer register and
// per-word decode of the serial instruction into a WS field.
module ctc_word_timer
    import ctc_pkg::*;
#(
    parameter int DIGITS     = 14,
    parameter int DIGIT_BITS = 4,
    parameter int EXP_DIGITS = 2,
    parameter int IS_START   = 45,
    parameter int IS_LEN     = 10,
    localparam int WORD_BITS = DIGITS * DIGIT_BITS,
    localparam int CW        = $clog2(WORD_BITS),
    localparam int PW        = $clog2(DIGITS)
) (
    input  logic          cph2,
    input  logic          nrst,
    input  logic          is,
    output logic          sync,
    output logic [CW-1:0] t_cnt,
    output logic [PW-1:0] digit,
    output logic          ws,
    output logic [PW-1:0] ptr,
    output logic          p_flag,
    output logic          word_end
);

    // pointer compare width: wide enough for both p and the 4-bit operand
    localparam int NW = (PW > 4) ? PW : 4;

    if (IS_START + IS_LEN > WORD_BITS) begin : g_bad_window
        $error("ctc_word_timer: instruction window exceeds the word");
    end
    if (IS_LEN < 10) begin : g_bad_len
        $error("ctc_word_timer: IS_LEN must hold a 10-bit instruction");
    end

    logic [IS_LEN-1:0] ibuf, ibuf_nxt;
    logic [PW-1:0]     p;
    logic              ws_en;
    ws_field_e         field;
    logic [CW:0]       t_ext;
    logic [3:0]        n;

    assign t_ext    = {1'b0, t_cnt};
    assign sync     = (t_ext >= (CW+1)'(IS_START)) && (t_ext < (CW+1)'(IS_START + IS_LEN));
    assign word_end = (t_cnt == CW'(WORD_BITS - 1));
    assign digit    = PW'(t_cnt / CW'(DIGIT_BITS));
    assign ptr      = p;

    // decode sees the post-shift buffer so a window ending at word_end still works
    assign ibuf_nxt = sync ? {is, ibuf[IS_LEN-1:1]} : ibuf;
    assign n        = ibuf_nxt[9:6];

    always_ff @(posedge cph2) begin
        if (!nrst) begin
            t_cnt  <= '0;
            ibuf   <= '0;
            p      <= '0;
            ws_en  <= 1'b0;
            field  <= WS_P;
            p_flag <= 1'b0;
        end else begin
            t_cnt <= word_end ? '0 : t_cnt + 1'b1;
            ibuf  <= ibuf_nxt;
            if (word_end) begin
                ws_en <= (ibuf_nxt[1:0] == ITYPE_ARITH);
                if (ibuf_nxt[1:0] == ITYPE_ARITH)
                    field <= ws_field_e'(ibuf_nxt[4:2]);
                if (ibuf_nxt[3:0] == IPTR) begin
                    case (ptr_op_e'(ibuf_nxt[5:4]))
                        P_SET:  if (NW'(n) < NW'(DIGITS)) p <= PW'(n);
                        P_TEST: p_flag <= (NW'(p) == NW'(n));
                        P_DEC:  p <= (p == '0) ? PW'(DIGITS - 1) : p - 1'b1;
                        P_INC:  p <= (p == PW'(DIGITS - 1)) ? '0 : p + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    ctc_ws_decode #(
        .DIGITS     (DIGITS),
        .EXP_DIGITS (EXP_DIGITS)
    ) u_ws_decode (
        .field (field),
        .digit (digit),
        .p     (p),
        .ws_en (ws_en),
        .ws    (ws)
    );

endmodule
